inst_trace_buf: RTL and testbench
=================================

# inst_trace_buf

Commit-side instruction trace buffer for the multi-issue MIPS core. Each cycle it takes up to LANES retired instructions, decodes each into a 6-character ASCII mnemonic, and pushes {pc, instr, lane, mnemonic} entries in lane order into a DEPTH-entry FIFO. A debug or simulation consumer drains the FIFO through a valid/ready port. Saturating commit, drop and optional per-class counters provide run statistics.

## Interface
- LANES, 2: commit lanes sampled per cycle; 1..4.
- DEPTH, 16: FIFO entries; power of two, ≥ LANES.
- CNT_W, 32: width of every statistics counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- commit_valid  in  LANES  per-lane retire strobe.
- commit_instr  in  32*LANES  lane i at bits [32i+31:32i].
- commit_pc  in  32*LANES  lane i PC, same packing.
- flush  in  1  empties FIFO; counters untouched.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head entry.
- out_pc  out  32  head PC.
- out_instr  out  32  head instruction word.
- out_lane  out  max(1,$clog2(LANES))  head lane index.
- out_ascii  out  48  head mnemonic, right-justified, zero-byte padded on the left.
- level  out  $clog2(DEPTH)+1  current occupancy.
- commit_cnt  out  CNT_W  valid commits seen, saturating.
- drop_cnt  out  CNT_W  commits lost to a full FIFO, saturating.
- cnt_alu, cnt_br, cnt_mem, cnt_sys  out  CNT_W each  class counters (see Configuration).

## Operation
- Decode per lane is combinational, then registered into the FIFO. Covered: SPECIAL funct AND OR XOR NOR SLL SRL SRA SLLV SRLV SRAV MFHI MTHI MFLO MTLO ADD ADDU SUB SUBU SLT SLTU MULT MULTU DIV DIVU JR JALR SYSCALL("SYSC") BREAK("BRE"); ANDI XORI LUI ORI ADDI ADDIU SLTI SLTIU J JAL BEQ BNE BGTZ BLEZ LB LBU LH LHU LW SB SH SW; REGIMM rt BGEZ BGEZAL BLTZ BLTZAL; COP0 ERET (32'h42000018), MTC0 (rs=00100), MFC0 (rs=00000), other rs "COP0". All-zero word is "NOP" and overrides SLL. Every other encoding, including unknown REGIMM rt, is "N-R".
- Classes: alu = SPECIAL arithmetic/logic/shift/move/mul/div plus immediate ALU ops (NOP included); br = J JAL JR JALR and all branches; mem = loads and stores; sys = SYSCALL BREAK ERET MTC0 MFC0 COP0. N-R is counted in no class.
- Push: free = DEPTH − level, sampled before any same-cycle pop. Valid lanes are accepted in ascending index order while free remains; remaining valid lanes are dropped and drop_cnt increments by the number dropped. Invalid lanes are skipped without consuming a slot.
- Pop: occurs when out_valid && out_ready. Push and pop in the same cycle are legal, and level changes by pushes − 1.
- commit_cnt increments by popcount(commit_valid) each cycle, whether entries are accepted, dropped or flushed.
- All counters saturate at 2^CNT_W − 1. Multi-lane increments that would overflow clamp to that value.
- flush: next cycle level = 0 and pointers are reset. Same-cycle pushes are discarded and not counted as dropped. A same-cycle pop is ignored.

## Timing
- Reset: level 0, out_valid 0, out_pc/out_instr/out_ascii/out_lane 0, all counters 0, pointers 0. The same applies to reset asserted mid-operation; no entry survives it.
- Latency: commit in cycle N makes the entry visible at the head no earlier than cycle N+1. If the FIFO was empty, out_valid rises in N+1.
- out_* are driven from registered storage and stay stable while out_valid && !out_ready.
- Full with a same-cycle pop: the pop does not create push space in that cycle.
- Pointer wrap-around is modulo DEPTH. level reaches exactly DEPTH when full.

## Configuration
- TRACE_CLASS_CNT_EN defined: cnt_alu/cnt_br/cnt_mem/cnt_sys count accepted and dropped valid commits per class, with the same saturation rules as the other counters.
- TRACE_CLASS_CNT_EN undefined: the four class outputs are tied to 0 and no class-decode or counter logic is built. The FIFO and the commit/drop counters are unaffected.

## Test plan
- Reset, then lane0 = 32'h00000000 at pc 0xBFC00000, lane1 = 32'h8C080004 (LW): two entries, "NOP" lane 0 then "LW" lane 1; level = 2 one cycle later; commit_cnt = 2.
- DEPTH=16, out_ready=0, 9 cycles of both lanes valid: level saturates at 16; cycle 9 drops 2, drop_cnt = 2, commit_cnt = 18. A hold check confirms out_* stay unchanged.
- FIFO full, out_ready=1, both lanes valid: one pop and zero pushes, drop_cnt += 2, level = 15 next cycle.
- Lane0 invalid, lane1 = 32'h42000018: single entry "ERET" with out_lane = 1. 32'h04110003 decodes to "BGEZAL"; 32'h04050000 decodes to "N-R".
- flush asserted with both lanes valid at level 5: level = 0 next cycle, out_valid = 0, drop_cnt unchanged, commit_cnt += 2.
- With TRACE_CLASS_CNT_EN and CNT_W=4, preload near saturation via 15 ALU commits, then 2 more: cnt_alu = 15 and commit_cnt clamps at 15.

Source files
------------

// File: rtl/inst_trace_buf.sv
// inst_trace_buf: commit-side instruction trace FIFO with per-lane ASCII mnemonic decode.
// Optional per-class statistics counters are built when `TRACE_CLASS_CNT_EN is defined.
module inst_trace_buf #(
   parameter int unsigned LANES = 2,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 32
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [LANES-1:0]                             commit_valid,
   input  logic [32*LANES-1:0]                          commit_instr,
   input  logic [32*LANES-1:0]                          commit_pc,
   input  logic                                         flush,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [31:0]                                  out_pc,
   output logic [31:0]                                  out_instr,
   output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] out_lane,
   output logic [47:0]                                  out_ascii,
   output logic [$clog2(DEPTH):0]                       level,
   output logic [CNT_W-1:0]                             commit_cnt,
   output logic [CNT_W-1:0]                             drop_cnt,
   output logic [CNT_W-1:0]                             cnt_alu,
   output logic [CNT_W-1:0]                             cnt_br,
   output logic [CNT_W-1:0]                             cnt_mem,
   output logic [CNT_W-1:0]                             cnt_sys
);
   localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVW   = $clog2(DEPTH) + 1;
   localparam int unsigned SW    = ((CNT_W > LVW) ? CNT_W : LVW) + 1;
   localparam int unsigned NSLOT = 1 << AW;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                input logic [LVW-1:0]   inc);
      logic [SW-1:0] s;
      s = SW'(c) + SW'(inc);
      return (s > SW'({CNT_W{1'b1}})) ? '1 : s[CNT_W-1:0];
   endfunction

   // Mnemonics are right-justified: the size cast zero-fills the unused leading bytes.
   function automatic logic [47:0] mnem(input logic [31:0] w);
      logic [47:0] m;
      m = 48'("N-R");
      if (w == '0) begin
         m = 48'("NOP");
      end else begin
         case (w[31:26])
            6'h00: begin
               case (w[5:0])
                  6'h00: m = 48'("SLL");
                  6'h02: m = 48'("SRL");
                  6'h03: m = 48'("SRA");
                  6'h04: m = 48'("SLLV");
                  6'h06: m = 48'("SRLV");
                  6'h07: m = 48'("SRAV");
                  6'h08: m = 48'("JR");
                  6'h09: m = 48'("JALR");
                  6'h0C: m = 48'("SYSC");
                  6'h0D: m = 48'("BRE");
                  6'h10: m = 48'("MFHI");
                  6'h11: m = 48'("MTHI");
                  6'h12: m = 48'("MFLO");
                  6'h13: m = 48'("MTLO");
                  6'h18: m = 48'("MULT");
                  6'h19: m = 48'("MULTU");
                  6'h1A: m = 48'("DIV");
                  6'h1B: m = 48'("DIVU");
                  6'h20: m = 48'("ADD");
                  6'h21: m = 48'("ADDU");
                  6'h22: m = 48'("SUB");
                  6'h23: m = 48'("SUBU");
                  6'h24: m = 48'("AND");
                  6'h25: m = 48'("OR");
                  6'h26: m = 48'("XOR");
                  6'h27: m = 48'("NOR");
                  6'h2A: m = 48'("SLT");
                  6'h2B: m = 48'("SLTU");
                  default: ;
               endcase
            end
            6'h01: begin
               case (w[20:16])
                  5'h00: m = 48'("BLTZ");
                  5'h01: m = 48'("BGEZ");
                  5'h10: m = 48'("BLTZAL");
                  5'h11: m = 48'("BGEZAL");
                  default: ;
               endcase
            end
            6'h02: m = 48'("J");
            6'h03: m = 48'("JAL");
            6'h04: m = 48'("BEQ");
            6'h05: m = 48'("BNE");
            6'h06: m = 48'("BLEZ");
            6'h07: m = 48'("BGTZ");
            6'h08: m = 48'("ADDI");
            6'h09: m = 48'("ADDIU");
            6'h0A: m = 48'("SLTI");
            6'h0B: m = 48'("SLTIU");
            6'h0C: m = 48'("ANDI");
            6'h0D: m = 48'("ORI");
            6'h0E: m = 48'("XORI");
            6'h0F: m = 48'("LUI");
            6'h10: begin
               if (w == 32'h4200_0018)    m = 48'("ERET");
               else if (w[25:21] == 5'h04) m = 48'("MTC0");
               else if (w[25:21] == 5'h00) m = 48'("MFC0");
               else                        m = 48'("COP0");
            end
            6'h20: m = 48'("LB");
            6'h21: m = 48'("LH");
            6'h23: m = 48'("LW");
            6'h24: m = 48'("LBU");
            6'h25: m = 48'("LHU");
            6'h28: m = 48'("SB");
            6'h29: m = 48'("SH");
            6'h2B: m = 48'("SW");
            default: ;
         endcase
      end
      return m;
   endfunction

   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVW-1:0]   level_q;
   logic [CNT_W-1:0] commit_cnt_q, drop_cnt_q;

   logic [31:0]      pc_mem    [NSLOT];
   logic [31:0]      instr_mem [NSLOT];
   logic [LW-1:0]    lane_mem  [NSLOT];
   logic [47:0]      asc_mem   [NSLOT];

   logic [47:0]      asc  [LANES];
   logic [AW-1:0]    slot [LANES];
   logic [LANES-1:0] acc;
   logic [LVW-1:0]   n_valid, n_acc, n_drop, free;
   logic             pop;

   // Free space is taken before any same-cycle pop, so a full FIFO never accepts while draining.
   always_comb begin
      free    = LVW'(DEPTH) - level_q;
      n_valid = '0;
      n_acc   = '0;
      n_drop  = '0;
      acc     = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         asc[i]  = mnem(commit_instr[32*i +: 32]);
         slot[i] = wr_ptr_q + AW'(n_acc);
         if (commit_valid[i]) begin
            n_valid = n_valid + LVW'(1);
            if (n_acc < free) begin
               acc[i] = 1'b1;
               n_acc  = n_acc + LVW'(1);
            end else begin
               n_drop = n_drop + LVW'(1);
            end
         end
      end
   end

   assign pop = (level_q != '0) && out_ready;

   always_ff @(posedge clk) begin
      if (!rst && !flush) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (acc[i]) begin
               pc_mem[slot[i]]    <= commit_pc[32*i +: 32];
               instr_mem[slot[i]] <= commit_instr[32*i +: 32];
               lane_mem[slot[i]]  <= LW'(i);
               asc_mem[slot[i]]   <= asc[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         commit_cnt_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         commit_cnt_q <= sat_add(commit_cnt_q, n_valid);
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
         end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(n_acc);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            level_q    <= level_q + n_acc - LVW'(pop);
            drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
         end
      end
   end

   // Head fields read as zero whenever the FIFO is empty, including straight after reset.
   always_comb begin
      out_valid = (level_q != '0);
      out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
      out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
      out_lane  = out_valid ? lane_mem[rd_ptr_q]  : '0;
      out_ascii = out_valid ? asc_mem[rd_ptr_q]   : '0;
   end

   assign level      = level_q;
   assign commit_cnt = commit_cnt_q;
   assign drop_cnt   = drop_cnt_q;

`ifdef TRACE_CLASS_CNT_EN
   typedef enum logic [2:0] {CLS_NONE, CLS_ALU, CLS_BR, CLS_MEM, CLS_SYS} cls_e;

   function automatic cls_e classify(input logic [31:0] w);
      cls_e c;
      c = CLS_NONE;
      if (w == '0) begin
         c = CLS_ALU;
      end else begin
         case (w[31:26])
            6'h00: begin
               case (w[5:0])
                  6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h11, 6'h12, 6'h13,
                  6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                  6'h26, 6'h27, 6'h2A, 6'h2B: c = CLS_ALU;
                  6'h08, 6'h09:               c = CLS_BR;
                  6'h0C, 6'h0D:               c = CLS_SYS;
                  default: ;
               endcase
            end
            6'h01: if (w[20:16] inside {5'h00, 5'h01, 5'h10, 5'h11}) c = CLS_BR;
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: c = CLS_BR;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: c = CLS_ALU;
            6'h10: c = CLS_SYS;
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: c = CLS_MEM;
            default: ;
         endcase
      end
      return c;
   endfunction

   logic [LVW-1:0]   inc_alu, inc_br, inc_mem, inc_sys;
   logic [CNT_W-1:0] alu_q, br_q, mem_q, sys_q;

   always_comb begin
      inc_alu = '0;
      inc_br  = '0;
      inc_mem = '0;
      inc_sys = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (commit_valid[i]) begin
            case (classify(commit_instr[32*i +: 32]))
               CLS_ALU: inc_alu = inc_alu + LVW'(1);
               CLS_BR:  inc_br  = inc_br  + LVW'(1);
               CLS_MEM: inc_mem = inc_mem + LVW'(1);
               CLS_SYS: inc_sys = inc_sys + LVW'(1);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_q <= '0;
         br_q  <= '0;
         mem_q <= '0;
         sys_q <= '0;
      end else begin
         alu_q <= sat_add(alu_q, inc_alu);
         br_q  <= sat_add(br_q,  inc_br);
         mem_q <= sat_add(mem_q, inc_mem);
         sys_q <= sat_add(sys_q, inc_sys);
      end
   end

   assign cnt_alu = alu_q;
   assign cnt_br  = br_q;
   assign cnt_mem = mem_q;
   assign cnt_sys = sys_q;
`else
   assign cnt_alu = '0;
   assign cnt_br  = '0;
   assign cnt_mem = '0;
   assign cnt_sys = '0;
`endif

endmodule

// File: tb/tb_inst_trace_buf.sv
// Self-checking bench for inst_trace_buf: vector table plus scoreboard queue of expected head entries.
`timescale 1ns/1ps
module tb_inst_trace_buf;
   localparam int unsigned DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  cv  = '0;
   logic [63:0] ci  = '0;
   logic [63:0] cp  = '0;
   logic        fl  = 1'b0;
   logic        rdy = 1'b0;

   logic        out_valid;
   logic [31:0] out_pc, out_instr;
   logic [0:0]  out_lane;
   logic [47:0] out_ascii;
   logic [4:0]  level;
   logic [31:0] commit_cnt, drop_cnt, cnt_alu, cnt_br, cnt_mem, cnt_sys;

   logic [1:0]  sv = '0;
   logic [63:0] si = '0;
   logic [63:0] sp = '0;
   logic        s_valid;
   logic [31:0] s_pc, s_instr;
   logic [0:0]  s_lane;
   logic [47:0] s_ascii;
   logic [4:0]  s_level;
   logic [3:0]  s_commit, s_drop, s_alu, s_br, s_mem, s_sys;

   always #5 clk = ~clk;

   inst_trace_buf #(.LANES(2), .DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .commit_valid(cv), .commit_instr(ci), .commit_pc(cp),
      .flush(fl), .out_valid(out_valid), .out_ready(rdy), .out_pc(out_pc),
      .out_instr(out_instr), .out_lane(out_lane), .out_ascii(out_ascii), .level(level),
      .commit_cnt(commit_cnt), .drop_cnt(drop_cnt), .cnt_alu(cnt_alu), .cnt_br(cnt_br),
      .cnt_mem(cnt_mem), .cnt_sys(cnt_sys));

   inst_trace_buf #(.LANES(2), .DEPTH(DEPTH), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .commit_valid(sv), .commit_instr(si), .commit_pc(sp),
      .flush(1'b0), .out_valid(s_valid), .out_ready(1'b1), .out_pc(s_pc),
      .out_instr(s_instr), .out_lane(s_lane), .out_ascii(s_ascii), .level(s_level),
      .commit_cnt(s_commit), .drop_cnt(s_drop), .cnt_alu(s_alu), .cnt_br(s_br),
      .cnt_mem(s_mem), .cnt_sys(s_sys));

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        lane;
      logic [47:0] asc;
   } ent_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [47:0] asc;
      int          cls;
   } lane_t;

   typedef struct {
      logic [31:0] instr;
      logic [47:0] asc;
      int          cls;
   } vec_t;

   ent_t   q[$];
   longint mcommit, mdrop;
   longint mcls[5];
   int     total = 0;
   int     bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic lane_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [47:0] asc, input int cls);
      lane_t l;
      l.instr = instr;
      l.pc    = pc;
      l.asc   = asc;
      l.cls   = cls;
      return l;
   endfunction

   task automatic check_counters();
      chk("level", 64'(level), 64'(q.size()));
      chk("commit_cnt", 64'(commit_cnt), 64'(mcommit));
      chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
`ifdef TRACE_CLASS_CNT_EN
      chk("cnt_alu", 64'(cnt_alu), 64'(mcls[1]));
      chk("cnt_br",  64'(cnt_br),  64'(mcls[2]));
      chk("cnt_mem", 64'(cnt_mem), 64'(mcls[3]));
      chk("cnt_sys", 64'(cnt_sys), 64'(mcls[4]));
`else
      chk("cnt_class_off", {cnt_alu, cnt_br | cnt_mem | cnt_sys}, 64'd0);
`endif
   endtask

   // One clock cycle: drive, check head against the scoreboard, update model, check after edge.
   task automatic step(input logic [1:0] v, input lane_t l0, input lane_t l1,
                       input logic r, input logic f);
      lane_t       ln[2];
      int unsigned free, pushed;
      bit          pop;
      ent_t        e;
      ln[0] = l0;
      ln[1] = l1;
      @(negedge clk);
      cv  = v;
      ci  = {l1.instr, l0.instr};
      cp  = {l1.pc, l0.pc};
      rdy = r;
      fl  = f;
      #1;
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("head_pc", 64'(out_pc), 64'(q[0].pc));
         chk("head_instr", 64'(out_instr), 64'(q[0].instr));
         chk("head_lane", 64'(out_lane), 64'(q[0].lane));
         chk("head_ascii", 64'(out_ascii), 64'(q[0].asc));
      end
      for (int i = 0; i < 2; i++) begin
         if (v[i]) begin
            mcommit++;
            mcls[ln[i].cls]++;
         end
      end
      if (f) begin
         q.delete();
      end else begin
         free   = DEPTH - q.size();
         pushed = 0;
         pop    = (q.size() > 0) && r;
         for (int i = 0; i < 2; i++) begin
            if (v[i]) begin
               if (pushed < free) begin
                  e.pc    = ln[i].pc;
                  e.instr = ln[i].instr;
                  e.lane  = 1'(i);
                  e.asc   = ln[i].asc;
                  q.push_back(e);
                  pushed++;
               end else begin
                  mdrop++;
               end
            end
         end
         if (pop) void'(q.pop_front());
      end
      @(posedge clk);
      #1;
      check_counters();
   endtask

   task automatic model_reset();
      q.delete();
      mcommit = 0;
      mdrop   = 0;
      foreach (mcls[k]) mcls[k] = 0;
   endtask

   vec_t  tab[23];
   lane_t idle;
   lane_t addu0, addu1;

   initial begin
      tab[0]  = '{32'h0000_0000, 48'("NOP"),    1};
      tab[1]  = '{32'h8C08_0004, 48'("LW"),     3};
      tab[2]  = '{32'h4200_0018, 48'("ERET"),   4};
      tab[3]  = '{32'h0411_0003, 48'("BGEZAL"), 2};
      tab[4]  = '{32'h0405_0000, 48'("N-R"),    0};
      tab[5]  = '{32'h0085_1021, 48'("ADDU"),   1};
      tab[6]  = '{32'h0000_000C, 48'("SYSC"),   4};
      tab[7]  = '{32'h0000_000D, 48'("BRE"),    4};
      tab[8]  = '{32'h0002_1080, 48'("SLL"),    1};
      tab[9]  = '{32'h03E0_0008, 48'("JR"),     2};
      tab[10] = '{32'h3C01_1234, 48'("LUI"),    1};
      tab[11] = '{32'h1022_0003, 48'("BEQ"),    2};
      tab[12] = '{32'hAC22_0000, 48'("SW"),     3};
      tab[13] = '{32'h4080_6000, 48'("MTC0"),   4};
      tab[14] = '{32'h4002_6000, 48'("MFC0"),   4};
      tab[15] = '{32'h4280_0000, 48'("COP0"),   4};
      tab[16] = '{32'hFC00_0000, 48'("N-R"),    0};
      tab[17] = '{32'h0000_0001, 48'("N-R"),    0};
      tab[18] = '{32'h0400_0001, 48'("BLTZ"),   2};
      tab[19] = '{32'h2442_0001, 48'("ADDIU"),  1};
      tab[20] = '{32'h0C00_0010, 48'("JAL"),    2};
      tab[21] = '{32'h0043_001A, 48'("DIV"),    1};
      tab[22] = '{32'h0000_0810, 48'("MFHI"),   1};
      idle = mk(32'h0, 32'h0, 48'h0, 0);
      model_reset();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_head", {out_pc, out_instr}, 64'd0);
      chk("rst_ascii_lane", {out_ascii, 15'd0, out_lane}, 64'd0);
      check_counters();
      @(negedge clk);
      rst = 1'b0;

      // NOP + LW in one cycle, then drain both
      step(2'b11, mk(32'h0000_0000, 32'hBFC0_0000, 48'("NOP"), 1),
                  mk(32'h8C08_0004, 32'hBFC0_0004, 48'("LW"), 3), 1'b0, 1'b0);
      step(2'b00, idle, idle, 1'b1, 1'b0);
      step(2'b00, idle, idle, 1'b1, 1'b0);

      // Fill to full with the consumer stalled; the ninth cycle drops both lanes
      for (int k = 0; k < 9; k++) begin
         addu0 = mk(32'h0085_1021, 32'h0040_0000 + 32'(8*k), 48'("ADDU"), 1);
         addu1 = mk(32'h0085_1023, 32'h0040_0004 + 32'(8*k), 48'("SUBU"), 1);
         step(2'b11, addu0, addu1, 1'b0, 1'b0);
      end
      chk("full_level", 64'(level), 64'd16);
      // Full with a pop: no space for the same-cycle pushes
      step(2'b11, mk(32'h1022_0003, 32'h0050_0000, 48'("BEQ"), 2),
                  mk(32'hAC22_0000, 32'h0050_0004, 48'("SW"), 3), 1'b1, 1'b0);
      chk("full_pop_level", 64'(level), 64'd15);
      repeat (10) step(2'b00, idle, idle, 1'b1, 1'b0);
      chk("pre_flush_level", 64'(level), 64'd5);
      // Flush with both lanes valid: nothing kept, nothing dropped
      step(2'b11, mk(32'h0000_000C, 32'h0060_0000, 48'("SYSC"), 4),
                  mk(32'h0000_000D, 32'h0060_0004, 48'("BRE"), 4), 1'b1, 1'b1);
      step(2'b00, idle, idle, 1'b1, 1'b0);

      // Lane-1-only commit
      step(2'b10, idle, mk(32'h4200_0018, 32'h0070_0004, 48'("ERET"), 4), 1'b1, 1'b0);
      step(2'b00, idle, idle, 1'b1, 1'b0);

      // Decode table, one commit per cycle on lane 0, consumer always ready
      for (int i = 0; i < 23; i++)
         step(2'b01, mk(tab[i].instr, 32'h0080_0000 + 32'(4*i), tab[i].asc, tab[i].cls),
              idle, 1'b1, 1'b0);
      step(2'b00, idle, idle, 1'b1, 1'b0);

      // Reset mid-operation with entries held
      step(2'b11, mk(32'h0085_1021, 32'h0090_0000, 48'("ADDU"), 1),
                  mk(32'h8C08_0004, 32'h0090_0004, 48'("LW"), 3), 1'b0, 1'b0);
      @(negedge clk);
      cv  = '0;
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_head", {out_pc, out_instr}, 64'd0);
      check_counters();
      @(negedge clk);
      rst = 1'b0;

      // Narrow counters: saturation at 15
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         sv = 2'b01;
         si = {32'h0085_1021, 32'h0085_1021};
         sp = {32'h00A0_0004, 32'h00A0_0000 + 32'(4*k)};
      end
      @(negedge clk);
      sv = 2'b00;
      #1;
      chk("sat_commit15", 64'(s_commit), 64'd15);
      chk("sat_level1", 64'(s_level), 64'd1);
      @(negedge clk);
      sv = 2'b11;
      @(negedge clk);
      sv = 2'b00;
      #1;
      chk("sat_commit_clamp", 64'(s_commit), 64'd15);
      chk("sat_drop", 64'(s_drop), 64'd0);
      chk("sat_level2", 64'(s_level), 64'd2);
`ifdef TRACE_CLASS_CNT_EN
      chk("sat_alu_clamp", 64'(s_alu), 64'd15);
      chk("sat_other_cls", {52'd0, s_br | s_mem | s_sys}, 64'd0);
`else
      chk("sat_cls_off", {48'd0, s_alu, s_br, s_mem, s_sys}, 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
